// File: rtl/bgr_pkg.sv
// Shared types and defaults for the bandgap start-up sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bgr_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_KICK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_READY  = 3'd4,
        ST_DISCHG = 3'd5,
        ST_FAULT  = 3'd6
    } bgr_state_t;

    localparam int KICK_CYCLES_DEF    = 16;
    localparam int SETTLE_CYCLES_DEF  = 1024;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    localparam int DEBOUNCE_DEF       = 8;
    localparam int MAX_RETRY_DEF      = 3;
    localparam int TRIM_W_DEF         = 5;
    localparam int TRIM_DEFAULT_DEF   = 16;

    // Width of the shared cycle counter: must hold the largest cycle parameter.
    function automatic int cnt_width(input int kick_cycles, input int settle_cycles,
                                     input int timeout_cycles);
        int m;
        m = kick_cycles;
        if (settle_cycles > m)  m = settle_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous window comparator output.
// Latency: 2 cycles from d to q.
// Backpressure: none, free-running level path.
module bgr_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap enable/kick/settle/qualify sequencer with trim hold; BGR_RETRY_EN enables retries.
// Latency: registered Moore outputs, change on the edge that samples the triggering input.
// Backpressure: none; start is a level request, trim_wr a single-cycle strobe.
module bgr_startup_ctrl
    import bgr_pkg::*;
#(
    parameter int KICK_CYCLES    = KICK_CYCLES_DEF,
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int DEBOUNCE       = DEBOUNCE_DEF,
    parameter int MAX_RETRY      = MAX_RETRY_DEF,
    parameter int TRIM_W         = TRIM_W_DEF,
    parameter int TRIM_DEFAULT   = TRIM_DEFAULT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              trim_wr,
    input  logic [TRIM_W-1:0] trim_data,
    input  logic              cmp_ok,
    output logic              bgr_en,
    output logic              kick,
    output logic [TRIM_W-1:0] trim_code,
    output logic              ready,
    output logic              fault,
    output logic [2:0]        state_o
);

    localparam logic [2:0] S_OFF    = ST_OFF;
    localparam logic [2:0] S_KICK   = ST_KICK;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_CHECK  = ST_CHECK;
    localparam logic [2:0] S_READY  = ST_READY;
    localparam logic [2:0] S_DISCHG = ST_DISCHG;
    localparam logic [2:0] S_FAULT  = ST_FAULT;

    localparam int CW = cnt_width(KICK_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int DW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0]     KICK_LAST    = CW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0]     SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]     TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]     DEB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0]     RETRY_MAX    = RW'(MAX_RETRY);
    localparam logic [TRIM_W-1:0] TRIM_RST     = TRIM_W'(TRIM_DEFAULT);

`ifdef BGR_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] deb, deb_nx;
    logic [RW-1:0] retry, retry_nx;
    logic          cmp_s;
    logic          fail;
    logic          restart;
    logic          clr;

    bgr_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_ok),
        .q     (cmp_s)
    );

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        fail     = 1'b0;
        restart  = 1'b0;
        case (state)
            S_OFF:    if (start) state_nx = S_KICK;
            S_KICK:   if (cnt == KICK_LAST) state_nx = S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) state_nx = S_CHECK;
            S_CHECK: begin
                if (cmp_s && deb == DEB_LAST)   state_nx = S_READY;
                else if (cnt == TIMEOUT_LAST)   fail = 1'b1;
            end
            S_READY:  if (!cmp_s && deb == DEB_LAST) fail = 1'b1;
            S_DISCHG: if (cnt == KICK_LAST) state_nx = S_KICK;
            S_FAULT:  state_nx = S_FAULT;
            default:  state_nx = S_OFF;
        endcase

        if (fail) begin
            if (RETRY_EN && retry < RETRY_MAX) begin
                retry_nx = retry + 1'b1;
                state_nx = S_DISCHG;
            end else begin
                state_nx = S_FAULT;
            end
        end

        // A retrim invalidates any qualification in progress, so re-settle from scratch.
        if (trim_wr && (state == S_SETTLE || state == S_CHECK || state == S_READY)) begin
            state_nx = S_SETTLE;
            retry_nx = retry;
            restart  = 1'b1;
        end

        if (!start) begin
            state_nx = S_OFF;
            retry_nx = '0;
            restart  = 1'b1;
        end
    end

    assign clr = restart || (state_nx != state);

    always_comb begin
        cnt_nx = '0;
        deb_nx = '0;
        if (!clr) begin
            cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
            if (state == S_CHECK)      deb_nx = cmp_s  ? deb + 1'b1 : '0;
            else if (state == S_READY) deb_nx = !cmp_s ? deb + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_OFF;
            cnt       <= '0;
            deb       <= '0;
            retry     <= '0;
            bgr_en    <= 1'b0;
            kick      <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            trim_code <= TRIM_RST;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            deb    <= deb_nx;
            retry  <= retry_nx;
            bgr_en <= (state_nx == S_KICK) || (state_nx == S_SETTLE) ||
                      (state_nx == S_CHECK) || (state_nx == S_READY);
            kick   <= (state_nx == S_KICK);
            ready  <= (state_nx == S_READY);
            fault  <= (state_nx == S_FAULT);
            if (trim_wr) trim_code <= trim_data;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed scenarios plus randomized traffic against an elapsed-time phase model.
`timescale 1ns/1ps
module tb_bgr_startup_ctrl;

    localparam int K  = 4;
    localparam int S  = 8;
    localparam int T  = 16;
    localparam int D  = 4;
    localparam int MR = 2;
    localparam int TW = 5;
`ifdef BGR_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          trim_wr = 1'b0;
    logic          cmp_ok = 1'b0;
    logic [TW-1:0] trim_data = '0;
    logic          bgr_en, kick, ready, fault;
    logic [TW-1:0] trim_code;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    bgr_startup_ctrl #(
        .KICK_CYCLES    (K),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .DEBOUNCE       (D),
        .MAX_RETRY      (MR),
        .TRIM_W         (TW),
        .TRIM_DEFAULT   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .trim_wr   (trim_wr),
        .trim_data (trim_data),
        .cmp_ok    (cmp_ok),
        .bgr_en    (bgr_en),
        .kick      (kick),
        .trim_code (trim_code),
        .ready     (ready),
        .fault     (fault),
        .state_o   (state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: phase code, cycles completed in phase, run of qualifying comparator samples.
    int            m_ph = 0;
    int            m_elapsed = 0;
    int            m_run = 0;
    int            m_retries = 0;
    logic [TW-1:0] m_trim = '0;
    bit            m_sq[$];
    bit            m_valid = 1'b0;

    task automatic model_step();
        bit s;
        bit mfail;
        bit restart;
        int nxt;
        cyc++;
        if (!rst_n) begin
            m_ph = 0; m_elapsed = 0; m_run = 0; m_retries = 0; m_trim = TW'(16);
            m_sq.delete(); m_sq.push_back(1'b0); m_sq.push_back(1'b0);
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        s = m_sq.pop_front();
        m_sq.push_back(cmp_ok);
        if (trim_wr) m_trim = trim_data;
        m_elapsed++;
        if (m_ph == 3)      m_run = s ? m_run + 1 : 0;
        else if (m_ph == 4) m_run = s ? 0 : m_run + 1;
        nxt = m_ph; mfail = 1'b0; restart = 1'b0;
        if (!start) begin
            nxt = 0; m_retries = 0; restart = 1'b1;
        end else if (trim_wr && m_ph >= 2 && m_ph <= 4) begin
            nxt = 2; restart = 1'b1;
        end else begin
            case (m_ph)
                0: nxt = 1;
                1: if (m_elapsed == K) nxt = 2;
                2: if (m_elapsed == S) nxt = 3;
                3: if (m_run == D) nxt = 4; else if (m_elapsed == T) mfail = 1'b1;
                4: if (m_run == D) mfail = 1'b1;
                5: if (m_elapsed == K) nxt = 1;
                default: ;
            endcase
        end
        if (mfail) begin
            if (RETRY && m_retries < MR) begin m_retries++; nxt = 5; end
            else nxt = 6;
        end
        if (restart || nxt != m_ph) begin
            m_ph = nxt; m_elapsed = 0; m_run = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [11:0] exp_v;
        @(negedge clk);
        if (m_valid) begin
            exp_v = {(m_ph >= 1 && m_ph <= 4), (m_ph == 1), (m_ph == 4), (m_ph == 6),
                     3'(m_ph), m_trim};
            chk("cycle_outputs", int'({bgr_en, kick, ready, fault, state_o, trim_code}),
                int'(exp_v));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, kcnt, kfirst, dcnt;
        // Reset, then idle with start low.
        step(3);
        rst_n = 1'b1;
        cmp_ok = 1'b1;
        step(5);
        chk("rst_state", state_o, 0);
        chk("rst_trim", trim_code, 16);
        chk("rst_outs", int'({bgr_en, kick, ready, fault}), 0);

        // Clean start-up with comparator in window.
        c0 = cyc; start = 1'b1; kcnt = 0; kfirst = -1;
        for (int i = 0; i < 60 && !ready; i++) begin
            step(1);
            if (kick) begin
                kcnt++;
                if (kfirst < 0) kfirst = cyc - c0;
            end
        end
        chk("kick_start", kfirst, 1);
        chk("kick_len", kcnt, 4);
        chk("ready_lat", cyc - c0, 17);

        // Short dropout is filtered; a full debounce window of lows is not.
        cmp_ok = 1'b0; step(3); cmp_ok = 1'b1; step(10);
        chk("ready_hold", ready, 1);
        cmp_ok = 1'b0; step(4); cmp_ok = 1'b1; step(3);
        chk("loss_state", state_o, RETRY ? 5 : 6);
        chk("loss_ready", ready, 0);
        start = 1'b0; step(1);
        chk("stop_state", state_o, 0);
        chk("stop_outs", int'({bgr_en, kick, ready, fault}), 0);
        start = 1'b1;
        for (int i = 0; i < 60 && !ready; i++) step(1);
        chk("relock", ready, 1);

        // Retrim from READY re-settles.
        c0 = cyc; trim_data = 5'd7; trim_wr = 1'b1; step(1); trim_wr = 1'b0;
        chk("trim_val", trim_code, 7);
        chk("trim_state", state_o, 2);
        for (int i = 0; i < 40 && !ready; i++) step(1);
        chk("trim_relock", cyc - c0, 13);

        // Mid-operation reset.
        rst_n = 1'b0; step(1);
        chk("midrst_state", state_o, 0);
        chk("midrst_trim", trim_code, 16);
        rst_n = 1'b1;

        // Comparator never qualifies: retries then fault.
        start = 1'b0; cmp_ok = 1'b0; step(3);
        c0 = cyc; start = 1'b1; dcnt = 0;
        for (int i = 0; i < 200 && !fault; i++) begin
            step(1);
            if (state_o == 3'd5) dcnt++;
        end
        chk("fault_time", cyc - c0, RETRY ? 93 : 29);
        chk("dischg_cycles", dcnt, RETRY ? 8 : 0);
        start = 1'b0; step(1);
        chk("fault_clear", int'({fault, state_o}), 0);

        // start drop wins over a retrim in CHECK, but the trim still loads.
        start = 1'b1;
        for (int i = 0; i < 40 && state_o != 3'd3; i++) step(1);
        chk("reach_check", state_o, 3);
        start = 1'b0; trim_wr = 1'b1; trim_data = 5'd21; step(1); trim_wr = 1'b0;
        chk("drop_trim_state", state_o, 0);
        chk("drop_trim_val", trim_code, 21);

        // Randomized traffic; the per-cycle compare covers every cycle.
        start = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if (start) begin
                if ($urandom_range(0, 149) == 0) start = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                start = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) cmp_ok = ~cmp_ok;
            trim_wr   = ($urandom_range(0, 79) == 0);
            trim_data = TW'($urandom);
            step(1);
        end
        rst_n = 1'b1; trim_wr = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
